// File: rtl/bpu.sv
// Branch prediction unit: 16-entry BHT of 2-bit saturating counters feeding a
// combinational fetch-stage prediction, plus an id/ex stage pipeline that
// aligns the prediction with the execute stage.
module bpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] inst_i,
    input  logic [2:0]  hold_flag_i,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_addr_i,
    input  logic        upd_taken_i,
    output logic        pred_flag_o,
    output logic [31:0] pred_addr_o,
    output logic        bp_result_o
);

    localparam int unsigned BHT_DEPTH = 16;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned CNT_W     = 2;

    localparam logic [CNT_W-1:0] CNT_SN = 2'b00;
    localparam logic [CNT_W-1:0] CNT_WN = 2'b01;
    localparam logic [CNT_W-1:0] CNT_ST = 2'b11;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] HOLD_IF    = 3'd2;
    localparam logic [2:0] HOLD_ID    = 3'd3;

    logic [CNT_W-1:0] bht [BHT_DEPTH];

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [CNT_W-1:0] upd_next;
    logic [31:0]      branch_imm;
    logic             is_branch;
    logic             id_pred;
    logic             ex_pred;

    // Address bits that never select a counter and non-offset instruction fields.
    logic unused_ok;
    assign unused_ok = ^{upd_addr_i[31:6], upd_addr_i[1:0], inst_i[24:12]};

    assign fetch_idx  = inst_addr_i[5:2];
    assign upd_idx    = upd_addr_i[5:2];
    assign is_branch  = (inst_i[6:0] == OPC_BRANCH);
    assign branch_imm = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

    // Fetch-stage prediction; reads the pre-update counter value.
    always_comb begin
        pred_flag_o = 1'b0;
        pred_addr_o = 32'h0;
        if (is_branch && bht[fetch_idx][CNT_W-1]) begin
            pred_flag_o = 1'b1;
            pred_addr_o = inst_addr_i + branch_imm;
        end
    end

    // Saturating increment/decrement of the counter being trained.
    always_comb begin
        upd_next = bht[upd_idx];
        if (upd_taken_i) begin
            if (bht[upd_idx] != CNT_ST) upd_next = bht[upd_idx] + CNT_W'(1);
        end else begin
            if (bht[upd_idx] != CNT_SN) upd_next = bht[upd_idx] - CNT_W'(1);
        end
    end

    // BHT storage; reset returns every counter to weakly-not-taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_WN;
        end else if (upd_valid_i) begin
            bht[upd_idx] <= upd_next;
        end
    end

    // Prediction pipeline following the if_id / id_ex flush behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pred <= 1'b0;
            ex_pred <= 1'b0;
        end else begin
            id_pred <= (hold_flag_i >= HOLD_IF) ? 1'b0 : pred_flag_o;
            ex_pred <= (hold_flag_i == HOLD_ID) ? 1'b0 : id_pred;
        end
    end

    assign bp_result_o = ex_pred;

endmodule
